seq_mult_q88: RTL and testbench
===============================

Name: seq_mult_q88

Overview:
- Multi-cycle signed shift-add multiplier; the responder side of the strobe/done multiply handshake used by the dot-product and transform engines.
- Accepts one operand pair per request and returns the full 2·NA-bit product plus a Q-format slice after a fixed latency.
- Carries one aux tag bit through each request.
- Small area, one adder, intended for tiny-GPU vertex math.

Parameters:
- NA, 16, operand width (signed two's complement).
- LGNA, 4, log2(NA); width of the bit counter.
- FRAC, 8, fractional bits of the Q format (Q8.8 default); o_q = product bits [FRAC+NA-1:FRAC].

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- i_stb  in  1  request strobe; sampled only while o_busy=0.
- i_a  in  NA  signed multiplicand.
- i_b  in  NA  signed multiplier.
- i_aux  in  1  tag, latched with the request.
- o_busy  out  1  high while a multiply is in progress.
- o_done  out  1  one-cycle pulse; o_p/o_q/o_aux valid.
- o_p  out  2*NA  signed full product.
- o_q  out  NA  Q-format product slice.
- o_aux  out  1  tag of the completed request.

Behaviour:
- Reset (async, active-high): o_busy=0, o_done=0, o_p=0, o_q=0, o_aux=0, counter=0, state=IDLE.
- Reset asserted mid-operation aborts the multiply; no o_done is produced.
- States:
  - IDLE: i_stb=1 at edge T latches |i_a|, |i_b|, sign = a[NA-1]^b[NA-1], and i_aux; clears the accumulator and counter; sets o_busy=1; goes to BUSY.
  - BUSY: each cycle, if bit[count] of |b| is 1, add |a|<<count into the 2·NA-bit accumulator; count++.
  - BUSY, after the NA-th step (count==NA-1): the next cycle produces the result and returns to IDLE.
- Latency: o_busy is high for cycles T+1..T+NA. o_done=1 for exactly one cycle at T+NA+1, with o_busy=0 in that cycle.
- Result registers:
  - o_p = sign ? -acc : acc, in 2·NA bits.
  - o_q = o_p[FRAC+NA-1:FRAC], wrapping with no saturation.
  - o_p, o_q and o_aux hold their values until the next o_done.
- Width rule: (-2^(NA-1))·(-2^(NA-1)) = 2^(2NA-2) fits in o_p. Magnitude of -2^(NA-1) is computed in NA+1 bits to avoid overflow.
- Back-to-back: i_stb high in the o_done cycle is accepted (o_busy=0), giving one result every NA+1 cycles.
- i_stb while o_busy=1 is ignored; there is no queueing and no error flag.
- Zero operand: runs the full NA cycles; o_p=0 with no negative zero.
- i_a, i_b and i_aux may change after the accept edge without affecting the result.

Optional Feature:
- Macro: SEQ_MULT_Q_ROUND_EN.
- Defined: o_q = (o_p + 2^(FRAC-1))[FRAC+NA-1:FRAC], i.e. round-half-up. Wraps on overflow (0x7FFF.FF rounds to 0x8000). Adds one registered adder at the done stage; latency is unchanged.
- Undefined: o_q is plain truncation (floor toward -inf) of o_p. o_p is identical in both builds.

Test Plan:
- i_a=0x0180 (1.5), i_b=0x0200 (2.0), i_aux=1, stb at T → o_done at T+17; o_p=0x00030000, o_q=0x0300, o_aux=1; o_busy high T+1..T+16.
- i_a=0xFF00 (-1.0), i_b=0x0080 (0.5) → o_p=0xFFFF8000, o_q=0xFF80. Then i_a=i_b=0x8000 → o_p=0x40000000, o_q=0x0000.
- Back-to-back: second stb (0x0100×0x0300) asserted in the first o_done cycle → second o_done exactly 17 cycles later, o_q=0x0300. The first result holds until then.
- stb with 0x0200×0x0200 while busy on 0x0100×0x0100 → ignored. Only one o_done, with o_q=0x0100.
- Reset pulsed at T+5 of a request → all outputs 0 immediately; no o_done. A new stb after release completes normally.
- i_a=0x0001, i_b=0x0080 → o_p=0x00000080. o_q=0x0000 without SEQ_MULT_Q_ROUND_EN; o_q=0x0001 with it.

Source files
------------

// File: rtl/seq_mult_q88.sv
// Multi-cycle signed shift-add multiplier (one adder), strobe/done handshake, Q-format slice.
// Optional build macro SEQ_MULT_Q_ROUND_EN: o_q is rounded half-up instead of truncated.
module seq_mult_q88 #(
  parameter int NA   = 16,
  parameter int LGNA = 4,
  parameter int FRAC = 8
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            i_stb,
  input  logic [NA-1:0]   i_a,
  input  logic [NA-1:0]   i_b,
  input  logic            i_aux,
  output logic            o_busy,
  output logic            o_done,
  output logic [2*NA-1:0] o_p,
  output logic [NA-1:0]   o_q,
  output logic            o_aux
);

  localparam int PW = 2 * NA;

  typedef enum logic {IDLE, BUSY} state_t;

  state_t          state, state_nxt;
  logic            accept, last;
  logic [NA:0]     a_ext, a_mag_in, mag_a;
  logic [NA-1:0]   b_mag_in, mag_b;
  logic            sign, aux;
  logic [LGNA-1:0] count;
  logic [PW-1:0]   acc, addend, acc_sum, prod, q_src;

  // |a| needs NA+1 bits so that -2^(NA-1) has a representable magnitude.
  assign a_ext    = {i_a[NA-1], i_a};
  assign a_mag_in = a_ext[NA] ? -a_ext : a_ext;
  assign b_mag_in = i_b[NA-1] ? -i_b : i_b;

  assign addend  = mag_b[count] ? (PW'(mag_a) << count) : '0;
  assign acc_sum = acc + addend;
  assign prod    = sign ? -acc_sum : acc_sum;

`ifdef SEQ_MULT_Q_ROUND_EN
  assign q_src = prod + (PW'(1) << (FRAC - 1));
`else
  assign q_src = prod;
`endif

  assign o_busy = (state == BUSY);

  // NOTE: every output of a combinational block gets a default first, so no path infers a latch.
  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    last      = 1'b0;
    case (state)
      IDLE: begin
        if (i_stb) begin
          accept    = 1'b1;
          state_nxt = BUSY;
        end
      end
      BUSY: begin
        if (count == LGNA'(NA - 1)) begin
          last      = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // NOTE: clocked state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mag_a  <= '0;
      mag_b  <= '0;
      sign   <= 1'b0;
      aux    <= 1'b0;
      acc    <= '0;
      count  <= '0;
      o_done <= 1'b0;
      o_p    <= '0;
      o_q    <= '0;
      o_aux  <= 1'b0;
    end else begin
      o_done <= last;
      if (accept) begin
        mag_a <= a_mag_in;
        mag_b <= b_mag_in;
        sign  <= i_a[NA-1] ^ i_b[NA-1];
        aux   <= i_aux;
        acc   <= '0;
        count <= '0;
      end else if (state == BUSY) begin
        acc   <= acc_sum;
        count <= count + 1'b1;
      end
      // Final step folds its partial product straight into the result registers.
      if (last) begin
        o_p   <= prod;
        o_q   <= NA'(q_src >> FRAC);
        o_aux <= aux;
      end
    end
  end

endmodule

// File: tb/tb_seq_mult_q88.sv
// Self-checking bench for seq_mult_q88: directed handshake cases plus random operands vs. an arithmetic model.
module tb_seq_mult_q88;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        i_stb = 1'b0;
  logic [15:0] i_a = '0;
  logic [15:0] i_b = '0;
  logic        i_aux = 1'b0;
  logic        o_busy, o_done, o_aux;
  logic [31:0] o_p;
  logic [15:0] o_q;

  int          n_assert = 0;
  int          n_fail = 0;
  logic [31:0] last_p = '0;

  seq_mult_q88 dut (
    .clk(clk), .reset(reset), .i_stb(i_stb), .i_a(i_a), .i_b(i_b), .i_aux(i_aux),
    .o_busy(o_busy), .o_done(o_done), .o_p(o_p), .o_q(o_q), .o_aux(o_aux)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] model_p(input logic [15:0] a, input logic [15:0] b);
    longint x;
    x = longint'($signed(a)) * longint'($signed(b));
    return x[31:0];
  endfunction

  function automatic logic [15:0] model_q(input logic [31:0] p);
    logic [31:0] t;
`ifdef SEQ_MULT_Q_ROUND_EN
    t = p + 32'h0000_0080;
`else
    t = p;
`endif
    return t[23:8];
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Presents a request for one edge, then scrambles the inputs to prove they are latched.
  task automatic start(input logic [15:0] a, input logic [15:0] b, input logic aux);
    i_stb = 1'b1;
    i_a   = a;
    i_b   = b;
    i_aux = aux;
    tick();
    i_stb = 1'b0;
    i_a   = 16'($urandom);
    i_b   = 16'($urandom);
    i_aux = 1'($urandom);
  endtask

  // Called c0 cycles after the accept edge; expects o_done on the 17th sampled cycle.
  task automatic wait_done(input string tag, input logic [31:0] ep, input logic [15:0] eq,
                           input logic ea, input int c0);
    int cyc, busy_n, hold_bad;
    cyc = c0;
    busy_n = c0 - 1;
    hold_bad = 0;
    while (!o_done && cyc < 40) begin
      if (o_busy) busy_n++;
      if (o_p !== last_p) hold_bad++;
      tick();
      cyc++;
    end
    check({tag, "_latency"}, 64'(cyc), 64'd17);
    check({tag, "_busy_cycles"}, 64'(busy_n), 64'd16);
    check({tag, "_hold"}, 64'(hold_bad), 64'd0);
    check({tag, "_busy_at_done"}, 64'(o_busy), 64'd0);
    check({tag, "_p"}, 64'(o_p), 64'(ep));
    check({tag, "_q"}, 64'(o_q), 64'(eq));
    check({tag, "_aux"}, 64'(o_aux), 64'(ea));
    last_p = ep;
  endtask

  task automatic idle_no_done(input string tag, input int n);
    int dones;
    dones = 0;
    for (int i = 0; i < n; i++) begin
      tick();
      if (o_done) dones++;
    end
    check({tag, "_no_done"}, 64'(dones), 64'd0);
  endtask

  initial begin
    logic [15:0] ra, rb;
    logic        raux;
    logic [15:0] corners [5];
    logic [31:0] ep;
    corners[0] = 16'h8000; corners[1] = 16'h7FFF; corners[2] = 16'h0000;
    corners[3] = 16'hFFFF; corners[4] = 16'h0001;

    #1;
    check("reset_busy", 64'(o_busy), 64'd0);
    check("reset_done", 64'(o_done), 64'd0);
    check("reset_p", 64'(o_p), 64'd0);
    check("reset_q", 64'(o_q), 64'd0);
    check("reset_aux", 64'(o_aux), 64'd0);
    tick();
    tick();
    reset = 1'b0;
    tick();

    // 1.5 * 2.0
    start(16'h0180, 16'h0200, 1'b1);
    wait_done("d1", 32'h0003_0000, 16'h0300, 1'b1, 1);
    tick();
    check("d1_done_pulse", 64'(o_done), 64'd0);
    check("d1_p_held", 64'(o_p), 64'h0003_0000);

    // -1.0 * 0.5, then most-negative squared
    start(16'hFF00, 16'h0080, 1'b0);
    wait_done("d2", 32'hFFFF_8000, 16'hFF80, 1'b0, 1);
    tick();
    start(16'h8000, 16'h8000, 1'b1);
    wait_done("d3", 32'h4000_0000, 16'h0000, 1'b1, 1);

    // Back-to-back: new request in the done cycle
    start(16'h0100, 16'h0300, 1'b0);
    wait_done("b2b", 32'h0003_0000, 16'h0300, 1'b0, 1);
    tick();

    // Strobe while busy is ignored
    start(16'h0100, 16'h0100, 1'b1);
    tick();
    tick();
    i_stb = 1'b1; i_a = 16'h0200; i_b = 16'h0200; i_aux = 1'b0;
    tick();
    tick();
    i_stb = 1'b0;
    wait_done("ign", 32'h0001_0000, 16'h0100, 1'b1, 5);
    idle_no_done("ign", 25);

    // Reset mid-operation
    start(16'h0100, 16'h0300, 1'b1);
    for (int i = 0; i < 4; i++) tick();
    reset = 1'b1;
    #1;
    check("rst_mid_busy", 64'(o_busy), 64'd0);
    check("rst_mid_done", 64'(o_done), 64'd0);
    check("rst_mid_p", 64'(o_p), 64'd0);
    check("rst_mid_q", 64'(o_q), 64'd0);
    check("rst_mid_aux", 64'(o_aux), 64'd0);
    tick();
    reset = 1'b0;
    last_p = '0;
    idle_no_done("rst_mid", 30);
    start(16'h0180, 16'h0200, 1'b0);
    wait_done("after_rst", 32'h0003_0000, 16'h0300, 1'b0, 1);
    tick();

    // Tiny product: truncates to 0, rounds to 1
    start(16'h0001, 16'h0080, 1'b1);
`ifdef SEQ_MULT_Q_ROUND_EN
    wait_done("tiny", 32'h0000_0080, 16'h0001, 1'b1, 1);
`else
    wait_done("tiny", 32'h0000_0080, 16'h0000, 1'b1, 1);
`endif
    tick();

    // Zero operand with a negative partner: no negative zero
    start(16'h0000, 16'h8001, 1'b0);
    wait_done("zero", 32'h0000_0000, 16'h0000, 1'b0, 1);

    // Random operands, mixing corners, back-to-back and gaps
    for (int n = 0; n < 24; n++) begin
      ra   = ($urandom_range(0, 3) == 0) ? corners[$urandom_range(0, 4)] : 16'($urandom);
      rb   = ($urandom_range(0, 3) == 0) ? corners[$urandom_range(0, 4)] : 16'($urandom);
      raux = 1'($urandom);
      if ($urandom_range(0, 1) == 1) begin
        for (int g = $urandom_range(1, 4); g > 0; g--) tick();
      end
      ep = model_p(ra, rb);
      start(ra, rb, raux);
      wait_done($sformatf("rnd%0d", n), ep, model_q(ep), raux, 1);
    end
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
